// File: rtl/filter_line_engine.sv
// Line sequencer + 3-tap [1 2 1]/4 edge-clamped filter between the sdram read port A and write port B.
// Optional sharpen mode (mode port) is built only when FILTER_SHARPEN_EN is defined.
module filter_line_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
`ifdef FILTER_SHARPEN_EN
  input  logic              mode,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address_a,
  output logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              wren_a,
  output logic              wren_b,
  input  logic [DATA_W-1:0] q_a,
  input  logic [DATA_W-1:0] q_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W+1:0]   cyc_q;
  logic [ADDR_W-1:0]   len_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   wrAddr_q;
  logic [DATA_W-1:0]   pixCur_q;
  logic [DATA_W-1:0]   pixPrev_q;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_W-1:0]   addrA_q;
  logic [ADDR_W-1:0]   addrB_q;
  logic [DATA_W-1:0]   dataB_q;
  logic                wrenB_q;
`ifdef FILTER_SHARPEN_EN
  logic                mode_q;
`endif

  logic [ADDR_W+1:0]   lenExt;
  logic                nextValid;
  logic [DATA_W-1:0]   tapLeft;
  logic [DATA_W-1:0]   tapRight;
  logic [DATA_W+1:0]   blurSum;
  logic [DATA_W-1:0]   pixOut_d;
  logic                unusedQb;

  assign lenExt   = {2'b00, len_q};
  assign unusedQb = ^q_b;

  // During the cycle cyc_q = i+3 the filter emits y[i]; q_a then holds x[i+1] unless i is the last pixel.
  always_comb begin
    nextValid = (cyc_q <= lenExt + 1'b1);
    tapLeft   = (cyc_q == 3) ? pixCur_q : pixPrev_q;
    tapRight  = nextValid ? q_a : pixCur_q;
    blurSum   = {2'b00, tapLeft} + {1'b0, pixCur_q, 1'b0} + {2'b00, tapRight};
    pixOut_d  = blurSum[DATA_W+1:2];
  end

`ifdef FILTER_SHARPEN_EN
  logic [DATA_W:0]          pairSum;
  logic signed [DATA_W+2:0] sharpDiff;
  logic [DATA_W-1:0]        sharpOut;

  always_comb begin
    pairSum   = {1'b0, tapLeft} + {1'b0, tapRight};
    sharpDiff = $signed({2'b00, pixCur_q, 1'b0}) - $signed({3'b000, pairSum[DATA_W:1]});
    sharpOut  = sharpDiff[DATA_W-1:0];
    if (sharpDiff[DATA_W+2]) begin
      sharpOut = '0;
    end else if (|sharpDiff[DATA_W+1:DATA_W]) begin
      sharpOut = '1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      len_q     <= '0;
      src_q     <= '0;
      wrAddr_q  <= '0;
      pixCur_q  <= '0;
      pixPrev_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addrA_q   <= '0;
      addrB_q   <= '0;
      dataB_q   <= '0;
      wrenB_q   <= 1'b0;
`ifdef FILTER_SHARPEN_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q  <= 1'b0;
          wrenB_q <= 1'b0;
          if (start) begin
            src_q    <= src_base;
            wrAddr_q <= dst_base;
            len_q    <= length;
            cyc_q    <= {{(ADDR_W+1){1'b0}}, 1'b1};
`ifdef FILTER_SHARPEN_EN
            mode_q   <= mode;
`endif
            if (length != '0) begin
              state_q <= READ;
              busy_q  <= 1'b1;
              addrA_q <= src_base;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        READ, DRAIN: begin
          cyc_q <= cyc_q + 1'b1;
          if (state_q == READ) begin
            if (cyc_q < lenExt) begin
              addrA_q <= src_q + cyc_q[ADDR_W-1:0];
            end else begin
              state_q <= DRAIN;
            end
          end
          if (cyc_q >= 2 && cyc_q <= lenExt + 1'b1) begin
            pixPrev_q <= pixCur_q;
            pixCur_q  <= q_a;
          end
          // Each write lands three cycles after its centre pixel's read, so in-place jobs stay correct.
          if (cyc_q >= 3 && cyc_q <= lenExt + 2'd2) begin
            wrenB_q  <= 1'b1;
            addrB_q  <= wrAddr_q;
            wrAddr_q <= wrAddr_q + 1'b1;
`ifdef FILTER_SHARPEN_EN
            dataB_q  <= mode_q ? sharpOut : pixOut_d;
`else
            dataB_q  <= pixOut_d;
`endif
          end else begin
            wrenB_q <= 1'b0;
          end
          if (state_q == DRAIN && cyc_q == lenExt + 2'd3) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          wrenB_q <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign address_a = addrA_q;
  assign address_b = addrB_q;
  assign data_b    = dataB_q;
  assign wren_b    = wrenB_q;
  assign data_a    = '0;
  assign wren_a    = 1'b0;

endmodule

// File: tb/tb_filter_line_engine.sv
// Directed bench for filter_line_engine with a 1-cycle-latency RAM model; sharpen tests need FILTER_SHARPEN_EN.
module tb_filter_line_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] srcBase = '0;
  logic [15:0] dstBase = '0;
  logic [15:0] lenIn = '0;
  logic        modeIn = 1'b0;
  logic        busy, done, wrenA, wrenB;
  logic [15:0] addrA, addrB;
  logic [7:0]  dataA, dataB;
  logic [7:0]  qA = '0;
  logic [7:0]  qB = '0;

  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  logic        obsBusy [0:15];
  logic        obsDone [0:15];
  logic        obsWrenB[0:15];
  logic        obsPortA[0:15];
  logic [15:0] obsAddrA[0:15];
  logic [15:0] obsAddrB[0:15];
  logic [7:0]  obsDataB[0:15];

  filter_line_engine #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_base(srcBase), .dst_base(dstBase), .length(lenIn),
`ifdef FILTER_SHARPEN_EN
    .mode(modeIn),
`endif
    .busy(busy), .done(done),
    .address_a(addrA), .address_b(addrB),
    .data_a(dataA), .data_b(dataB),
    .wren_a(wrenA), .wren_b(wrenB),
    .q_a(qA), .q_b(qB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wrenB) mem[addrB] <= dataB;
    qA <= mem[addrA];
  end

  // Starts a job and records outputs for cycles 1..ncyc; returns at the negedge of cycle ncyc.
  task automatic runJob(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                        input logic m, input int ncyc);
    @(negedge clk);
    srcBase = s; dstBase = d; lenIn = n; modeIn = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      obsBusy[c]  = busy;
      obsDone[c]  = done;
      obsWrenB[c] = wrenB;
      obsPortA[c] = wrenA | (|dataA);
      obsAddrA[c] = addrA;
      obsAddrB[c] = addrB;
      obsDataB[c] = dataB;
      if (c < ncyc) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (wrenB !== 1'b0 || wrenA !== 1'b0) begin errors++; $display("[TB] FAIL reset_wren got %b%b want 00", wrenA, wrenB); end
    checks++; if (addrA !== 16'h0 || addrB !== 16'h0) begin errors++; $display("[TB] FAIL reset_addr got %h %h want 0000 0000", addrA, addrB); end
    checks++; if (dataA !== 8'h0 || dataB !== 8'h0) begin errors++; $display("[TB] FAIL reset_data got %h %h want 00 00", dataA, dataB); end
    rst = 1'b0;
  endtask

  task automatic test_blur;
    logic [7:0] expY [0:3];
    expY[0] = 8'd12; expY[1] = 8'd20; expY[2] = 8'd30; expY[3] = 8'd37;
    mem[16'h0100] = 8'd10; mem[16'h0101] = 8'd20; mem[16'h0102] = 8'd30; mem[16'h0103] = 8'd40;
    runJob(16'h0100, 16'h0200, 16'd4, 1'b0, 9);
    for (int c = 1; c <= 9; c++) begin
      checks++; if (obsBusy[c] !== (c <= 7)) begin errors++; $display("[TB] FAIL blur_busy c=%0d got %b want %b", c, obsBusy[c], (c <= 7)); end
      checks++; if (obsDone[c] !== (c == 8)) begin errors++; $display("[TB] FAIL blur_done c=%0d got %b want %b", c, obsDone[c], (c == 8)); end
      checks++; if (obsWrenB[c] !== (c >= 4 && c <= 7)) begin errors++; $display("[TB] FAIL blur_wren c=%0d got %b want %b", c, obsWrenB[c], (c >= 4 && c <= 7)); end
      checks++; if (obsPortA[c] !== 1'b0) begin errors++; $display("[TB] FAIL blur_porta c=%0d got %b want 0", c, obsPortA[c]); end
      if (c <= 4) begin
        checks++; if (obsAddrA[c] !== 16'h0100 + 16'(c - 1)) begin errors++; $display("[TB] FAIL blur_addra c=%0d got %h want %h", c, obsAddrA[c], 16'h0100 + 16'(c - 1)); end
      end
      if (c >= 4 && c <= 7) begin
        checks++; if (obsAddrB[c] !== 16'h0200 + 16'(c - 4)) begin errors++; $display("[TB] FAIL blur_addrb c=%0d got %h want %h", c, obsAddrB[c], 16'h0200 + 16'(c - 4)); end
        checks++; if (obsDataB[c] !== expY[c-4]) begin errors++; $display("[TB] FAIL blur_data c=%0d got %0d want %0d", c, obsDataB[c], expY[c-4]); end
      end
    end
  endtask

  task automatic test_single_and_zero;
    mem[16'h0300] = 8'd99;
    runJob(16'h0300, 16'h0310, 16'd1, 1'b0, 6);
    for (int c = 1; c <= 6; c++) begin
      checks++; if (obsBusy[c] !== (c <= 4)) begin errors++; $display("[TB] FAIL n1_busy c=%0d got %b want %b", c, obsBusy[c], (c <= 4)); end
      checks++; if (obsDone[c] !== (c == 5)) begin errors++; $display("[TB] FAIL n1_done c=%0d got %b want %b", c, obsDone[c], (c == 5)); end
      checks++; if (obsWrenB[c] !== (c == 4)) begin errors++; $display("[TB] FAIL n1_wren c=%0d got %b want %b", c, obsWrenB[c], (c == 4)); end
    end
    checks++; if (obsDataB[4] !== 8'd99 || obsAddrB[4] !== 16'h0310) begin errors++; $display("[TB] FAIL n1_write got %0d@%h want 99@0310", obsDataB[4], obsAddrB[4]); end
    runJob(16'h0300, 16'h0320, 16'd0, 1'b0, 3);
    for (int c = 1; c <= 3; c++) begin
      checks++; if (obsDone[c] !== (c == 1)) begin errors++; $display("[TB] FAIL n0_done c=%0d got %b want %b", c, obsDone[c], (c == 1)); end
      checks++; if (obsBusy[c] !== 1'b0 || obsWrenB[c] !== 1'b0) begin errors++; $display("[TB] FAIL n0_idle c=%0d got busy=%b wren=%b want 0 0", c, obsBusy[c], obsWrenB[c]); end
    end
  endtask

  task automatic test_inplace_wrap;
    logic [15:0] a;
    logic [7:0]  expM [0:3];
    expM[0] = 8'd1; expM[1] = 8'd4; expM[2] = 8'd8; expM[3] = 8'd11;
    mem[16'hFFFE] = 8'd0; mem[16'hFFFF] = 8'd4; mem[16'h0000] = 8'd8; mem[16'h0001] = 8'd12;
    runJob(16'hFFFE, 16'hFFFE, 16'd4, 1'b0, 8);
    checks++; if (obsAddrA[3] !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_addra got %h want 0000", obsAddrA[3]); end
    checks++; if (obsAddrB[6] !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_addrb got %h want 0000", obsAddrB[6]); end
    for (int i = 0; i < 4; i++) begin
      a = 16'hFFFE + 16'(i);
      checks++; if (mem[a] !== expM[i]) begin errors++; $display("[TB] FAIL inplace_mem i=%0d got %0d want %0d", i, mem[a], expM[i]); end
    end
  endtask

  task automatic test_reset_midjob;
    for (int i = 0; i < 8; i++) mem[16'h0400 + 16'(i)] = 8'(i * 8);
    for (int i = 0; i < 8; i++) mem[16'h0480 + 16'(i)] = 8'hEE;
    @(negedge clk);
    srcBase = 16'h0400; dstBase = 16'h0480; lenIn = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (wrenB !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid got wren=%b busy=%b done=%b want 0 0 0", wrenB, busy, done); end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (wrenB !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rst_quiet c=%0d got wren=%b done=%b want 0 0", c, wrenB, done); end
    end
    checks++; if (mem[16'h0482] !== 8'hEE) begin errors++; $display("[TB] FAIL rst_nowrite got %h want ee", mem[16'h0482]); end
    checks++; if (mem[16'h0481] !== 8'd8) begin errors++; $display("[TB] FAIL rst_prewrite got %0d want 8", mem[16'h0481]); end
    runJob(16'h0100, 16'h0500, 16'd4, 1'b0, 8);
    checks++; if (obsDone[8] !== 1'b1) begin errors++; $display("[TB] FAIL rst_restart_done got %b want 1", obsDone[8]); end
    checks++; if (mem[16'h0503] !== 8'd37) begin errors++; $display("[TB] FAIL rst_restart_mem got %0d want 37", mem[16'h0503]); end
  endtask

  task automatic test_ignore_start;
    int doneCount;
    doneCount = 0;
    mem[16'h0700] = 8'hAB;
    @(negedge clk);
    srcBase = 16'h0100; dstBase = 16'h0600; lenIn = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (done) doneCount++;
      if (c == 2 || c == 8) begin
        srcBase = 16'h0300; dstBase = 16'h0700; lenIn = 16'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (c == 8) begin
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL ign_done got %b want 1", done); end
      end
      if (c >= 9) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_busy c=%0d got %b want 0", c, busy); end
      end
      @(negedge clk);
    end
    checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL ign_done_count got %0d want 1", doneCount); end
    checks++; if (mem[16'h0600] !== 8'd12 || mem[16'h0603] !== 8'd37) begin errors++; $display("[TB] FAIL ign_mem got %0d %0d want 12 37", mem[16'h0600], mem[16'h0603]); end
    checks++; if (mem[16'h0700] !== 8'hAB) begin errors++; $display("[TB] FAIL ign_other got %h want ab", mem[16'h0700]); end
  endtask

  task automatic test_back_to_back;
    runJob(16'h0100, 16'h0800, 16'd4, 1'b0, 8);
    checks++; if (obsDone[8] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_done got %b want 1", obsDone[8]); end
    runJob(16'h0300, 16'h0810, 16'd1, 1'b0, 5);
    checks++; if (obsBusy[1] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept got %b want 1", obsBusy[1]); end
    checks++; if (obsWrenB[4] !== 1'b1 || obsDataB[4] !== 8'd99 || obsAddrB[4] !== 16'h0810) begin errors++; $display("[TB] FAIL b2b_write got %b %0d@%h want 1 99@0810", obsWrenB[4], obsDataB[4], obsAddrB[4]); end
    checks++; if (obsDone[5] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_done got %b want 1", obsDone[5]); end
    checks++; if (mem[16'h0801] !== 8'd20) begin errors++; $display("[TB] FAIL b2b_mem got %0d want 20", mem[16'h0801]); end
  endtask

`ifdef FILTER_SHARPEN_EN
  task automatic test_sharpen;
    logic [7:0] expA [0:2];
    logic [7:0] expB [0:3];
    expA[0] = 8'd0; expA[1] = 8'd255; expA[2] = 8'd0;
    expB[0] = 8'd5; expB[1] = 8'd20; expB[2] = 8'd30; expB[3] = 8'd45;
    mem[16'h0900] = 8'd0; mem[16'h0901] = 8'd255; mem[16'h0902] = 8'd0;
    runJob(16'h0900, 16'h0A00, 16'd3, 1'b1, 7);
    for (int i = 0; i < 3; i++) begin
      checks++; if (obsWrenB[i+4] !== 1'b1 || obsDataB[i+4] !== expA[i]) begin errors++; $display("[TB] FAIL sharp_sat i=%0d got %0d want %0d", i, obsDataB[i+4], expA[i]); end
    end
    runJob(16'h0100, 16'h0A10, 16'd4, 1'b1, 8);
    for (int i = 0; i < 4; i++) begin
      checks++; if (obsWrenB[i+4] !== 1'b1 || obsDataB[i+4] !== expB[i]) begin errors++; $display("[TB] FAIL sharp_ramp i=%0d got %0d want %0d", i, obsDataB[i+4], expB[i]); end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_blur();
    test_single_and_zero();
    test_inplace_wrap();
    test_reset_midjob();
    test_ignore_start();
    test_back_to_back();
`ifdef FILTER_SHARPEN_EN
    test_sharpen();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_line_engine.md
# filter_line_engine

Sequencer and 3-tap horizontal filter that sits directly upstream/downstream of the dual-port `sdram` image buffer in Filter-GPU. It streams a line of pixels out of the RAM on port A, filters each pixel with a [1 2 1]/4 kernel (edge-clamped), and writes the results back through port B. It is started by a single-cycle `start` pulse and reports completion with a `done` pulse.

## Interface
- `ADDR_W`, 16, RAM address width (matches `sdram`)
- `DATA_W`, 8, pixel width (matches `sdram`); arithmetic below assumes 8
- `clk`  in  1  single clock; also drives both `sdram` clock inputs
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `src_base`  in  ADDR_W  first source pixel address; sampled with `start`
- `dst_base`  in  ADDR_W  first destination address; sampled with `start`
- `length`  in  ADDR_W  pixel count N; sampled with `start`
- `mode`  in  1  0 = blur, 1 = sharpen; sampled with `start`; present only with `FILTER_SHARPEN_EN`
- `busy`  out  1  high while a job is in progress
- `done`  out  1  one-cycle completion pulse
- `address_a`, `address_b`  out  ADDR_W  RAM port addresses
- `data_a`, `data_b`  out  DATA_W  RAM write data
- `wren_a`, `wren_b`  out  1  RAM write enables
- `q_a`, `q_b`  in  DATA_W  RAM read data; `q_b` is unused

## Operation
- Port A is read-only: `wren_a` = 0 and `data_a` = 0 at all times. Port B is write-only.
- RAM read latency is fixed at 1: `q_a` carries `mem[address_a]` in the cycle after the address is presented.
- FSM states:
  - IDLE -> READ when `start` = 1 and N > 0.
  - IDLE -> DONE when `start` = 1 and N = 0. No RAM accesses occur.
  - READ issues one address per cycle, src_base+0 .. src_base+N-1. After the last address it moves to DRAIN.
  - DRAIN -> DONE after the last write.
  - DONE -> IDLE after one cycle.
- Window: x[-1] = x[0] and x[N] = x[N-1] (edge clamp). For N = 1, all three taps are x[0].
- Blur: y[i] = (x[i-1] + 2·x[i] + x[i+1]) >> 2. Use a 10-bit sum and truncate.
- y[i] is written to dst_base+i.
- All address arithmetic wraps modulo 2^ADDR_W.
- In-place operation (dst_base == src_base) must give the correct result, because each write lags all reads that need that location. Any other src/dst overlap gives undefined results.
- `start` is ignored while `busy` = 1 or during DONE.
- `rst` mid-job returns to IDLE at the next edge. No further writes occur, and `done` is not pulsed.

## Timing
- Cycle 0 is the edge where `start` is sampled.
- Read of src_base+k: `address_a` is presented in cycle k+1, and x[k] appears on `q_a` in cycle k+2.
- y[i] is written in cycle i+4: `wren_b` = 1, `address_b` = dst_base+i, `data_b` = y[i]. Writes occur in consecutive cycles.
- `busy` is high in cycles 1..N+3.
- `done` = 1 in cycle N+4 only, and `busy` = 0 in that cycle.
- For N = 0: `done` is high in cycle 1, and `busy` never rises.
- Reset values: `busy`, `done`, `wren_a`, `wren_b` = 0; `address_a`, `address_b`, `data_a`, `data_b` = 0.
- Outside write cycles, `wren_b` = 0. `address_a` holds its last value when not reading.
- Back-to-back jobs: a new `start` is accepted in the cycle after `done`.

## Configuration
- `FILTER_SHARPEN_EN` defined:
  - The `mode` port exists.
  - With `mode` = 1: y[i] = clamp(2·x[i] − ((x[i-1] + x[i+1]) >> 1), 0, 255), computed in 11-bit signed arithmetic.
  - Latency and write timing are identical to blur.
- `FILTER_SHARPEN_EN` undefined: the `mode` port is absent, and only blur is implemented.

## Test plan
- Blur, src = 0x0100 holding 10, 20, 30, 40; dst = 0x0200; N = 4 -> writes 12, 20, 30, 37 to 0x0200..0x0203 in cycles 4..7; `done` in cycle 8.
- N = 1 with x = 99 -> single write of 99 in cycle 4; `done` in cycle 5. N = 0 -> `done` in cycle 1, no `wren_b`.
- In-place, src = dst = 0xFFFE, N = 4 with values 0, 4, 8, 12 -> addresses wrap to 0x0000/0x0001; memory ends as 1, 4, 8, 11.
- `rst` asserted in cycle 5 of an N = 8 job -> `wren_b` = 0 from cycle 6 on, no `done`, and a new `start` is then accepted normally. A `start` pulsed mid-job is ignored.
- (`FILTER_SHARPEN_EN`) mode = 1, x = 0, 255, 0 -> writes 0, 255, 0 (saturation both ways). x = 10, 20, 30, 40 -> writes 5, 20, 30, 45.
